// File: rtl/mac_pkg.sv
// Shared types and constants for the RMII receive path.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2,
      DROP     = 2'd3
   } rx_state_t;

   localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
   localparam logic [1:0]  SFD_DIBIT      = 2'b11;
   localparam logic [31:0] CRC32_POLY     = 32'hEDB88320;
   localparam logic [31:0] CRC32_RESIDUE  = 32'hC704DD7B;

   // One byte through the reflected (LSB-first) CRC-32.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      return c;
   endfunction

   // The register is kept in reflected form; the residue constant is in
   // standard bit order, so the register is bit-reversed before comparing.
   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/rmii_rx_if.sv
// PHY-side inputs and fabric-side byte stream of the RMII receiver.
// master: the receiver (consumes PHY signals, drives the stream).
// slave : the environment (drives PHY signals, observes the stream).
interface rmii_rx_if #(
   parameter int CNT_W = 11
) ();
   logic             crs_dv;
   logic [1:0]       rx_data;
   logic             rx_err;
   logic [7:0]       m_data;
   logic             m_valid;
   logic             m_sof;
   logic             m_eof;
   logic             m_err;
   logic [CNT_W-1:0] byte_cnt;

   modport master (
      input  crs_dv, rx_data, rx_err,
      output m_data, m_valid, m_sof, m_eof, m_err, byte_cnt
   );

   modport slave (
      output crs_dv, rx_data, rx_err,
      input  m_data, m_valid, m_sof, m_eof, m_err, byte_cnt
   );
endinterface

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 register (reflected, init all-ones, no final inversion).
// Only compiled when RMII_RX_FCS_CHECK_EN is defined, since only then is it used.
`ifdef RMII_RX_FCS_CHECK_EN
module crc32_d8
   import mac_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);
   logic [31:0] crc_q, crc_d;

   // Next CRC: clear wins over enable.
   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = 32'hFFFF_FFFF;
      end else if (en) begin
         crc_d = crc32_byte(crc_q, data);
      end
   end

   // CRC register.
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= 32'hFFFF_FFFF;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;
endmodule
`endif

// File: rtl/rmii_rx.sv
// RMII receive deframer: preamble/SFD hunt, LSB-first dibit-to-byte assembly,
// byte stream with sof/eof/err markers. One byte is held back so the last byte
// of a frame can carry eof when crs_dv falls.
// Optional FCS check: define RMII_RX_FCS_CHECK_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no carrier; waits for crs_dv (after crs_dv seen low once)
// PREAMBLE | counting 01 dibits, waiting for the 11 SFD dibit
// DATA     | assembling bytes, emitting the held byte on each completion
// DROP     | bad preamble or overflow; ignore until crs_dv falls
module rmii_rx
   import mac_pkg::*;
#(
   parameter int MAX_BYTES    = 1522,
   parameter int MIN_PREAMBLE = 8,
   parameter int CNT_W        = 11
) (
   input  logic     clk,
   input  logic     rst,
   rmii_rx_if.master bus
);
   localparam int PRE_W = $clog2(MIN_PREAMBLE + 1);

   logic       crs_dv;
   logic [1:0] rx_data;
   logic       rx_err;

   assign crs_dv  = bus.crs_dv;
   assign rx_data = bus.rx_data;
   assign rx_err  = bus.rx_err;

   rx_state_t        state_q, state_d;
   logic             armed_q, armed_d;
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [5:0]       shift_q, shift_d;
   logic [7:0]       hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             err_q, err_d;
   logic             first_q, first_d;
   logic [7:0]       m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d;
   logic             m_sof_q, m_sof_d;
   logic             m_eof_q, m_eof_d;
   logic             m_err_q, m_err_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

   logic       sfd_hit;
   logic       byte_done;
   logic [7:0] byte_new;
   logic       fcs_bad;

   assign sfd_hit   = (state_q == PREAMBLE) && crs_dv && (rx_data == SFD_DIBIT) &&
                      (pre_cnt_q >= PRE_W'(MIN_PREAMBLE));
   assign byte_done = (state_q == DATA) && crs_dv && (idx_q == 2'd3);
   assign byte_new  = {rx_data, shift_q};

`ifdef RMII_RX_FCS_CHECK_EN
   logic [31:0] crc_val;

   crc32_d8 u_crc (
      .clk  (clk),
      .rst  (rst),
      .clr  (sfd_hit),
      .en   (byte_done),
      .data (byte_new),
      .crc  (crc_val)
   );

   // Evaluated at eof with the last byte in the hold register, so the frame
   // length is byte_cnt_q + 1.
   assign fcs_bad = (byte_cnt_q < CNT_W'(3)) || (reflect32(crc_val) != CRC32_RESIDUE);
`else
   assign fcs_bad = 1'b0;
`endif

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q | ~crs_dv;
      pre_cnt_d   = pre_cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      err_d       = err_q;
      first_d     = first_q;
      m_data_d    = m_data_q;
      m_valid_d   = 1'b0;
      m_sof_d     = 1'b0;
      m_eof_d     = 1'b0;
      m_err_d     = 1'b0;
      byte_cnt_d  = byte_cnt_q;

      case (state_q)
         IDLE: begin
            if (crs_dv && armed_q) begin
               state_d   = PREAMBLE;
               pre_cnt_d = '0;
            end
         end

         PREAMBLE: begin
            if (!crs_dv) begin
               state_d = IDLE;
            end else if (sfd_hit) begin
               state_d     = DATA;
               idx_d       = 2'd0;
               byte_cnt_d  = '0;
               err_d       = 1'b0;
               hold_full_d = 1'b0;
               first_d     = 1'b1;
            end else begin
               case (rx_data)
                  2'b00: begin
                  end
                  PREAMBLE_DIBIT: begin
                     if (pre_cnt_q < PRE_W'(MIN_PREAMBLE)) begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                     end
                  end
                  default: state_d = DROP;
               endcase
            end
         end

         DATA: begin
            if (byte_done) begin
               err_d = err_q | rx_err;
               if (hold_full_q) begin
                  m_valid_d  = 1'b1;
                  m_data_d   = hold_q;
                  m_sof_d    = first_q;
                  first_d    = 1'b0;
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  // The completing byte would be number MAX_BYTES+1: close the
                  // frame on the held byte and discard the rest.
                  if (byte_cnt_q == CNT_W'(MAX_BYTES - 1)) begin
                     m_eof_d = 1'b1;
                     m_err_d = 1'b1;
                     state_d = DROP;
                  end
               end
               hold_d      = byte_new;
               hold_full_d = 1'b1;
               idx_d       = 2'd0;
            end else if (crs_dv) begin
               err_d = err_q | rx_err;
               case (idx_q)
                  2'd0:    shift_d[1:0] = rx_data;
                  2'd1:    shift_d[3:2] = rx_data;
                  2'd2:    shift_d[5:4] = rx_data;
                  default: shift_d      = shift_q;
               endcase
               idx_d = idx_q + 1'b1;
            end else begin
               state_d = IDLE;
               if (hold_full_q) begin
                  m_valid_d  = 1'b1;
                  m_data_d   = hold_q;
                  m_sof_d    = first_q;
                  m_eof_d    = 1'b1;
                  m_err_d    = err_q | (idx_q != 2'd0) | fcs_bad;
                  first_d    = 1'b0;
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
               hold_full_d = 1'b0;
            end
         end

         DROP: begin
            if (!crs_dv) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         armed_q     <= 1'b0;
         pre_cnt_q   <= '0;
         idx_q       <= 2'd0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         err_q       <= 1'b0;
         first_q     <= 1'b0;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         m_sof_q     <= 1'b0;
         m_eof_q     <= 1'b0;
         m_err_q     <= 1'b0;
         byte_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         pre_cnt_q   <= pre_cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         err_q       <= err_d;
         first_q     <= first_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_sof_q     <= m_sof_d;
         m_eof_q     <= m_eof_d;
         m_err_q     <= m_err_d;
         byte_cnt_q  <= byte_cnt_d;
      end
   end

   assign bus.m_data   = m_data_q;
   assign bus.m_valid  = m_valid_q;
   assign bus.m_sof    = m_sof_q;
   assign bus.m_eof    = m_eof_q;
   assign bus.m_err    = m_err_q;
   assign bus.byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_rmii_rx.sv
// Directed bench for rmii_rx. dut0 uses MAX_BYTES=1522, dut1 MAX_BYTES=4;
// both see the same PHY stimulus. Emissions are captured on the falling edge.
module tb_rmii_rx;

`ifdef RMII_RX_FCS_CHECK_EN
   localparam bit FCS = 1'b1;
`else
   localparam bit FCS = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]  d;
      logic        sof;
      logic        eof;
      logic        err;
      logic [10:0] cnt;
   } em_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       crs_dv;
   logic [1:0] rx_data;
   logic       rx_err;

   int checks = 0;
   int errors = 0;

   em_t        q0[$];
   em_t        q1[$];
   em_t        exp;
   logic [7:0] frm [0:63];

   always #10 clk = ~clk;

   rmii_rx_if #(.CNT_W(11)) bus0 ();
   rmii_rx_if #(.CNT_W(11)) bus1 ();

   assign bus0.crs_dv  = crs_dv;
   assign bus0.rx_data = rx_data;
   assign bus0.rx_err  = rx_err;
   assign bus1.crs_dv  = crs_dv;
   assign bus1.rx_data = rx_data;
   assign bus1.rx_err  = rx_err;

   rmii_rx #(.MAX_BYTES(1522), .MIN_PREAMBLE(8), .CNT_W(11)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   rmii_rx #(.MAX_BYTES(4), .MIN_PREAMBLE(8), .CNT_W(11)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   always @(negedge clk) begin
      if (bus0.m_valid === 1'b1)
         q0.push_back('{d: bus0.m_data, sof: bus0.m_sof, eof: bus0.m_eof,
                        err: bus0.m_err, cnt: bus0.byte_cnt});
      if (bus1.m_valid === 1'b1)
         q1.push_back('{d: bus1.m_data, sof: bus1.m_sof, eof: bus1.m_eof,
                        err: bus1.m_err, cnt: bus1.byte_cnt});
   end

   task automatic drive(input logic c, input logic [1:0] d, input logic e);
      @(negedge clk);
      crs_dv  = c;
      rx_data = d;
      rx_err  = e;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 2'b00, 1'b0);
   endtask

   // npre 01 dibits (nzero 00 dibits inserted after the first), SFD, nbytes
   // from frm, npart trailing dibits, then carrier off. rx_err is pulsed on
   // the second dibit of byte err_byte.
   task automatic send_frame(input int npre, input int nzero, input int nbytes,
                             input int npart, input int err_byte);
      for (int i = 0; i < npre; i++) begin
         if (i == 1) repeat (nzero) drive(1'b1, 2'b00, 1'b0);
         drive(1'b1, 2'b01, 1'b0);
      end
      drive(1'b1, 2'b11, 1'b0);
      for (int b = 0; b < nbytes; b++)
         for (int k = 0; k < 4; k++)
            drive(1'b1, frm[b][2*k +: 2], (b == err_byte) && (k == 1));
      for (int k = 0; k < npart; k++) drive(1'b1, 2'b10, 1'b0);
      idle(8);
   endtask

   task automatic load3();
      frm[0] = 8'hA5; frm[1] = 8'h3C; frm[2] = 8'h01;
   endtask

   task automatic test_reset();
      rst = 1'b1; crs_dv = 1'b0; rx_data = 2'b00; rx_err = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus0.m_valid, bus0.m_sof, bus0.m_eof, bus0.m_err} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000",
                            {bus0.m_valid, bus0.m_sof, bus0.m_eof, bus0.m_err});
      end
      checks++;
      if (bus0.m_data !== 8'h00) begin
         errors++; $display("FAIL reset_data: got %h expected 00", bus0.m_data);
      end
      checks++;
      if (bus0.byte_cnt !== 11'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d expected 0", bus0.byte_cnt);
      end
      rst = 1'b0;
      idle(4);
   endtask

   task automatic test_basic();
      load3(); q0.delete();
      send_frame(31, 0, 3, 0, -1);
      checks++;
      if (q0.size() !== 3) begin
         errors++; $display("FAIL basic_count: got %0d expected 3", q0.size());
      end
      for (int i = 0; i < 3 && i < q0.size(); i++) begin
         exp = '{d: frm[i], sof: (i == 0), eof: (i == 2), err: (i == 2) && FCS, cnt: 11'(i + 1)};
         checks++;
         if (q0[i] !== exp) begin
            errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, q0[i], exp);
         end
      end
      checks++;
      if (bus0.byte_cnt !== 11'd3) begin
         errors++; $display("FAIL basic_cnt_hold: got %0d expected 3", bus0.byte_cnt);
      end
   endtask

   task automatic test_align();
      load3(); q0.delete();
      send_frame(31, 0, 3, 2, -1);
      checks++;
      if (q0.size() !== 3) begin
         errors++; $display("FAIL align_count: got %0d expected 3", q0.size());
      end
      for (int i = 0; i < 3 && i < q0.size(); i++) begin
         exp = '{d: frm[i], sof: (i == 0), eof: (i == 2), err: (i == 2), cnt: 11'(i + 1)};
         checks++;
         if (q0[i] !== exp) begin
            errors++; $display("FAIL align_byte%0d: got %h expected %h", i, q0[i], exp);
         end
      end
   endtask

   task automatic test_rx_err();
      load3(); q0.delete();
      send_frame(31, 0, 3, 0, 1);
      checks++;
      if (q0.size() !== 3) begin
         errors++; $display("FAIL rxerr_count: got %0d expected 3", q0.size());
      end
      for (int i = 0; i < 3 && i < q0.size(); i++) begin
         exp = '{d: frm[i], sof: (i == 0), eof: (i == 2), err: (i == 2), cnt: 11'(i + 1)};
         checks++;
         if (q0[i] !== exp) begin
            errors++; $display("FAIL rxerr_byte%0d: got %h expected %h", i, q0[i], exp);
         end
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 6; i++) frm[i] = 8'((i + 1) * 16);
      q1.delete();
      send_frame(31, 0, 6, 0, -1);
      checks++;
      if (q1.size() !== 4) begin
         errors++; $display("FAIL ovf_count: got %0d expected 4", q1.size());
      end
      for (int i = 0; i < 4 && i < q1.size(); i++) begin
         exp = '{d: frm[i], sof: (i == 0), eof: (i == 3), err: (i == 3), cnt: 11'(i + 1)};
         checks++;
         if (q1[i] !== exp) begin
            errors++; $display("FAIL ovf_byte%0d: got %h expected %h", i, q1[i], exp);
         end
      end
      // Exactly MAX_BYTES bytes is a normal frame.
      q1.delete();
      send_frame(31, 0, 4, 0, -1);
      checks++;
      if (q1.size() !== 4) begin
         errors++; $display("FAIL max_count: got %0d expected 4", q1.size());
      end
      for (int i = 0; i < 4 && i < q1.size(); i++) begin
         exp = '{d: frm[i], sof: (i == 0), eof: (i == 3), err: (i == 3) && FCS, cnt: 11'(i + 1)};
         checks++;
         if (q1[i] !== exp) begin
            errors++; $display("FAIL max_byte%0d: got %h expected %h", i, q1[i], exp);
         end
      end
   endtask

   // The first preamble dibit is sampled in IDLE and is not counted, so
   // MIN_PREAMBLE counted dibits need MIN_PREAMBLE+1 on the wire.
   task automatic test_preamble();
      load3(); q0.delete();
      send_frame(4, 0, 3, 0, -1);
      checks++;
      if (q0.size() !== 0) begin
         errors++; $display("FAIL short_pre: got %0d bytes expected 0", q0.size());
      end
      send_frame(8, 3, 3, 0, -1);
      checks++;
      if (q0.size() !== 0) begin
         errors++; $display("FAIL pre_8: got %0d bytes expected 0", q0.size());
      end
      send_frame(9, 3, 3, 0, -1);
      checks++;
      if (q0.size() !== 3) begin
         errors++; $display("FAIL pre_9_count: got %0d expected 3", q0.size());
      end
      for (int i = 0; i < 3 && i < q0.size(); i++) begin
         exp = '{d: frm[i], sof: (i == 0), eof: (i == 2), err: (i == 2) && FCS, cnt: 11'(i + 1)};
         checks++;
         if (q0[i] !== exp) begin
            errors++; $display("FAIL pre_9_byte%0d: got %h expected %h", i, q0[i], exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      load3(); q0.delete();
      for (int i = 0; i < 31; i++) drive(1'b1, 2'b01, 1'b0);
      drive(1'b1, 2'b11, 1'b0);
      for (int b = 0; b < 2; b++)
         for (int k = 0; k < 4; k++) drive(1'b1, frm[b][2*k +: 2], 1'b0);
      drive(1'b1, 2'b01, 1'b0);
      drive(1'b1, 2'b00, 1'b0);
      checks++;
      if (bus0.m_data !== 8'hA5) begin
         errors++; $display("FAIL pre_rst_data: got %h expected a5", bus0.m_data);
      end
      @(negedge clk); rst = 1'b1; rx_data = 2'b01;
      @(negedge clk);
      checks++;
      if ({bus0.m_valid, bus0.m_sof, bus0.m_eof, bus0.m_err, bus0.m_data, bus0.byte_cnt} !== 23'd0) begin
         errors++; $display("FAIL rst_mid_outputs: got v%b s%b e%b r%b d%h c%0d expected all 0",
                            bus0.m_valid, bus0.m_sof, bus0.m_eof, bus0.m_err, bus0.m_data, bus0.byte_cnt);
      end
      @(negedge clk); rst = 1'b0;
      // Carrier still up after release: must not be mistaken for a new frame.
      for (int i = 0; i < 10; i++) drive(1'b1, 2'b01, 1'b0);
      drive(1'b1, 2'b11, 1'b0);
      for (int k = 0; k < 8; k++) drive(1'b1, 2'b01, 1'b0);
      idle(8);
      checks++;
      if (q0.size() !== 1) begin
         errors++; $display("FAIL rst_mid_count: got %0d expected 1", q0.size());
      end
      q0.delete();
      send_frame(31, 0, 3, 0, -1);
      checks++;
      if (q0.size() !== 3) begin
         errors++; $display("FAIL rst_next_count: got %0d expected 3", q0.size());
      end
      for (int i = 0; i < 3 && i < q0.size(); i++) begin
         exp = '{d: frm[i], sof: (i == 0), eof: (i == 2), err: (i == 2) && FCS, cnt: 11'(i + 1)};
         checks++;
         if (q0[i] !== exp) begin
            errors++; $display("FAIL rst_next_byte%0d: got %h expected %h", i, q0[i], exp);
         end
      end
   endtask

   task automatic test_fcs();
      logic [31:0] c;
      for (int i = 0; i < 56; i++) frm[i] = 8'(i * 7 + 3);
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < 56; i++)
         for (int b = 0; b < 8; b++)
            c = (c[0] ^ frm[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      c = ~c;
      for (int i = 0; i < 4; i++) frm[56 + i] = c[8*i +: 8];
      q0.delete();
      send_frame(31, 0, 60, 0, -1);
      checks++;
      if (q0.size() !== 60) begin
         errors++; $display("FAIL fcs_good_count: got %0d expected 60", q0.size());
      end else begin
         exp = '{d: frm[59], sof: 1'b0, eof: 1'b1, err: 1'b0, cnt: 11'd60};
         checks++;
         if (q0[59] !== exp) begin
            errors++; $display("FAIL fcs_good_last: got %h expected %h", q0[59], exp);
         end
      end
      frm[10] = frm[10] ^ 8'h04;
      q0.delete();
      send_frame(31, 0, 60, 0, -1);
      checks++;
      if (q0.size() !== 60) begin
         errors++; $display("FAIL fcs_bad_count: got %0d expected 60", q0.size());
      end else begin
         exp = '{d: frm[59], sof: 1'b0, eof: 1'b1, err: FCS, cnt: 11'd60};
         checks++;
         if (q0[59] !== exp) begin
            errors++; $display("FAIL fcs_bad_last: got %h expected %h", q0[59], exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_align();
      test_rx_err();
      test_overflow();
      test_preamble();
      test_reset_mid();
      test_fcs();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
